// File: rtl/cpu_io_port.sv
// Byte-wide CPU I/O port: show-ahead RX and TX FIFOs between the CPU and external handshakes.
// Define CPU_IO_PORT_ERR_EN to add sticky rx_underflow / tx_overflow flags with err_clear.
module cpu_io_port #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_rd,
  output logic [WIDTH-1:0]        cpu_in,
  output logic                    cpu_in_valid,
  input  logic                    cpu_wr,
  input  logic [WIDTH-1:0]        cpu_out,
  output logic                    cpu_out_full,
  input  logic [WIDTH-1:0]        ext_in_data,
  input  logic                    ext_in_valid,
  output logic                    ext_in_ready,
  output logic [WIDTH-1:0]        ext_out_data,
  output logic                    ext_out_valid,
  input  logic                    ext_out_ready,
  output logic [$clog2(DEPTH):0]  rx_count,
  output logic [$clog2(DEPTH):0]  tx_count
`ifdef CPU_IO_PORT_ERR_EN
  ,
  input  logic                    err_clear,
  output logic                    rx_underflow,
  output logic                    tx_overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [WIDTH-1:0] rx_mem_q [DEPTH];
  logic [WIDTH-1:0] tx_mem_q [DEPTH];

  ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;

  logic rx_empty, rx_full, rx_push, rx_pop;
  logic tx_empty, tx_full, tx_push, tx_pop;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]) && (rx_wptr_q[AW] != rx_rptr_q[AW]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]) && (tx_wptr_q[AW] != tx_rptr_q[AW]);

  assign rx_push = ext_in_valid && !rx_full;
  assign rx_pop  = cpu_rd && !rx_empty;
  assign tx_push = cpu_wr && !tx_full;
  assign tx_pop  = ext_out_ready && !tx_empty;

  assign ext_in_ready  = !rx_full;
  assign cpu_in_valid  = !rx_empty;
  assign cpu_out_full  = tx_full;
  assign ext_out_valid = !tx_empty;

  assign cpu_in       = rx_empty ? '0 : rx_mem_q[rx_rptr_q[AW-1:0]];
  assign ext_out_data = tx_empty ? '0 : tx_mem_q[tx_rptr_q[AW-1:0]];

  assign rx_count = rx_wptr_q - rx_rptr_q;
  assign tx_count = tx_wptr_q - tx_rptr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + ptr_t'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + ptr_t'(1);
    if (tx_push) tx_wptr_d = tx_wptr_q + ptr_t'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + ptr_t'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
    end
  end

  // NOTE: storage has no reset; empty-masking on the read side keeps stale contents invisible.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= ext_in_data;
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= cpu_out;
  end

`ifdef CPU_IO_PORT_ERR_EN
  logic rx_underflow_q, rx_underflow_d;
  logic tx_overflow_q, tx_overflow_d;

  // A set event in the same cycle as err_clear takes priority.
  always_comb begin
    rx_underflow_d = (cpu_rd && rx_empty) || (rx_underflow_q && !err_clear);
    tx_overflow_d  = (cpu_wr && tx_full)  || (tx_overflow_q  && !err_clear);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_underflow_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      rx_underflow_q <= rx_underflow_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  assign rx_underflow = rx_underflow_q;
  assign tx_overflow  = tx_overflow_q;
`endif

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed self-checking bench for cpu_io_port (DEPTH=4, WIDTH=8); honours CPU_IO_PORT_ERR_EN.
module tb_cpu_io_port;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             cpu_rd;
  logic [WIDTH-1:0] cpu_in;
  logic             cpu_in_valid;
  logic             cpu_wr;
  logic [WIDTH-1:0] cpu_out;
  logic             cpu_out_full;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic [2:0]       rx_count;
  logic [2:0]       tx_count;
`ifdef CPU_IO_PORT_ERR_EN
  logic             err_clear;
  logic             rx_underflow;
  logic             tx_overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cpu_io_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_rd        (cpu_rd),
    .cpu_in        (cpu_in),
    .cpu_in_valid  (cpu_in_valid),
    .cpu_wr        (cpu_wr),
    .cpu_out       (cpu_out),
    .cpu_out_full  (cpu_out_full),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .rx_count      (rx_count),
    .tx_count      (tx_count)
`ifdef CPU_IO_PORT_ERR_EN
    ,
    .err_clear     (err_clear),
    .rx_underflow  (rx_underflow),
    .tx_overflow   (tx_overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_in"},        32'(cpu_in), 0);
    check({tag, "_cpu_in_valid"},  32'(cpu_in_valid), 0);
    check({tag, "_ext_in_ready"},  32'(ext_in_ready), 1);
    check({tag, "_ext_out_valid"}, 32'(ext_out_valid), 0);
    check({tag, "_ext_out_data"},  32'(ext_out_data), 0);
    check({tag, "_cpu_out_full"},  32'(cpu_out_full), 0);
    check({tag, "_rx_count"},      32'(rx_count), 0);
    check({tag, "_tx_count"},      32'(tx_count), 0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_out = '0;
    ext_in_data = '0; ext_in_valid = 0; ext_out_ready = 0;
`ifdef CPU_IO_PORT_ERR_EN
    err_clear = 0;
`endif
    tick(); tick();
    check_reset_outputs("rst_held");
    reset = 1'b0;
    tick();

    // 1: load both FIFOs, then assert reset mid-cycle and look immediately
    ext_in_valid = 1; ext_in_data = 8'h5A; cpu_wr = 1; cpu_out = 8'hA5;
    tick();
    ext_in_valid = 0; cpu_wr = 0;
    check("pre_rst_rx_count", 32'(rx_count), 1);
    check("pre_rst_cpu_in", 32'(cpu_in), 'h5A);
    check("pre_rst_ext_out_data", 32'(ext_out_data), 'hA5);
    #3 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("rst_after");

    // 2: RX ordering
    foreach (ext_in_data[i]) ; // no-op keeps loop-free flow readable
    ext_in_valid = 1;
    ext_in_data = 8'h11; tick();
    ext_in_data = 8'h22; tick();
    ext_in_data = 8'h33; tick();
    ext_in_valid = 0;
    check("rx_ord_count", 32'(rx_count), 3);
    cpu_rd = 1;
    check("rx_ord_0", 32'(cpu_in), 'h11); tick();
    check("rx_ord_1", 32'(cpu_in), 'h22); tick();
    check("rx_ord_2", 32'(cpu_in), 'h33); tick();
    cpu_rd = 0;
    check("rx_ord_empty_data", 32'(cpu_in), 0);
    check("rx_ord_empty_valid", 32'(cpu_in_valid), 0);
`ifdef CPU_IO_PORT_ERR_EN
    check("rx_ord_no_underflow", 32'(rx_underflow), 0);
`endif

    // 3: RX full, held 5th byte, then underflowing pop
    ext_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ext_in_data = 8'(8'h40 + i);
      tick();
    end
    check("rx_full_ready", 32'(ext_in_ready), 0);
    check("rx_full_count", 32'(rx_count), 4);
    ext_in_data = 8'h44;
    tick();
    check("rx_full_held_count", 32'(rx_count), 4);
    check("rx_full_held_ready", 32'(ext_in_ready), 0);
    ext_in_valid = 0;
    cpu_rd = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rx_full_pop%0d", i), 32'(cpu_in), 32'('h40 + i));
      tick();
    end
    check("rx_drained_count", 32'(rx_count), 0);
    tick();
    cpu_rd = 0;
    check("rx_under_count", 32'(rx_count), 0);
    check("rx_under_valid", 32'(cpu_in_valid), 0);
    check("rx_under_ready", 32'(ext_in_ready), 1);
`ifdef CPU_IO_PORT_ERR_EN
    check("rx_underflow_set", 32'(rx_underflow), 1);
    tick();
    check("rx_underflow_sticky", 32'(rx_underflow), 1);
    err_clear = 1; tick(); err_clear = 0;
    check("rx_underflow_clr", 32'(rx_underflow), 0);
`endif

    // 4: TX overflow with consumer stalled, then drain
    ext_out_ready = 0;
    cpu_wr = 1;
    for (int i = 0; i < 5; i++) begin
      cpu_out = 8'(8'hA0 + i);
      tick();
    end
    cpu_wr = 0;
    check("tx_ovf_count", 32'(tx_count), 4);
    check("tx_ovf_full", 32'(cpu_out_full), 1);
`ifdef CPU_IO_PORT_ERR_EN
    check("tx_overflow_set", 32'(tx_overflow), 1);
    // set and clear together: set wins
    cpu_wr = 1; err_clear = 1; tick(); cpu_wr = 0; err_clear = 0;
    check("tx_overflow_set_wins", 32'(tx_overflow), 1);
    err_clear = 1; tick(); err_clear = 0;
    check("tx_overflow_clr", 32'(tx_overflow), 0);
`endif
    ext_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx_drain%0d", i), 32'(ext_out_data), 32'('hA0 + i));
      tick();
    end
    ext_out_ready = 0;
    check("tx_drain_valid", 32'(ext_out_valid), 0);
    check("tx_drain_data", 32'(ext_out_data), 0);
    check("tx_drain_count", 32'(tx_count), 0);

    // 5: simultaneous push/pop on full TX, non-empty RX, empty RX
    cpu_wr = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_out = 8'(8'hB0 + i);
      tick();
    end
    cpu_out = 8'hB4; ext_out_ready = 1;
    tick();
    cpu_wr = 0;
    check("sim_tx_count", 32'(tx_count), 3);
    check("sim_tx_head", 32'(ext_out_data), 'hB1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("sim_tx_drain%0d", i), 32'(ext_out_data), 32'('hB0 + i));
      tick();
    end
    ext_out_ready = 0;
    check("sim_tx_b4_dropped", 32'(ext_out_valid), 0);

    ext_in_valid = 1;
    ext_in_data = 8'hC0; tick();
    ext_in_data = 8'hC1; tick();
    ext_in_data = 8'hC2; cpu_rd = 1; tick();
    ext_in_valid = 0; cpu_rd = 0;
    check("sim_rx_count", 32'(rx_count), 2);
    check("sim_rx_head", 32'(cpu_in), 'hC1);
    cpu_rd = 1; tick(); tick(); cpu_rd = 0;
    check("sim_rx_drained", 32'(rx_count), 0);
    ext_in_valid = 1; ext_in_data = 8'hD7; cpu_rd = 1; tick();
    ext_in_valid = 0; cpu_rd = 0;
    check("sim_rx_empty_count", 32'(rx_count), 1);
    check("sim_rx_empty_head", 32'(cpu_in), 'hD7);
    cpu_rd = 1; tick(); cpu_rd = 0;
`ifdef CPU_IO_PORT_ERR_EN
    err_clear = 1; tick(); err_clear = 0;
`endif

    // 6: wrap-around streaming with random handshakes
    begin
      int rx_sent = 0, rx_got = 0, tx_sent = 0, tx_got = 0;
      logic rx_accept;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (rx_got == 20 && tx_got == 20) break;
        if (!ext_in_valid && rx_sent < 20 && $urandom_range(0, 1) == 1) begin
          ext_in_valid = 1;
          ext_in_data = 8'(rx_sent);
        end
        cpu_rd = ($urandom_range(0, 1) == 1);
        cpu_wr = (tx_sent < 20) && !cpu_out_full && ($urandom_range(0, 1) == 1);
        cpu_out = 8'(tx_sent);
        ext_out_ready = ($urandom_range(0, 1) == 1);
        if (cpu_rd && cpu_in_valid) begin
          check("wrap_rx", 32'(cpu_in), 32'(rx_got));
          rx_got++;
        end
        if (ext_out_ready && ext_out_valid) begin
          check("wrap_tx", 32'(ext_out_data), 32'(tx_got));
          tx_got++;
        end
        if (cpu_wr) tx_sent++;
        rx_accept = ext_in_valid && ext_in_ready;
        tick();
        if (rx_accept) begin
          ext_in_valid = 0;
          rx_sent++;
        end
      end
      cpu_rd = 0; cpu_wr = 0; ext_out_ready = 0; ext_in_valid = 0;
      check("wrap_rx_total", 32'(rx_got), 20);
      check("wrap_tx_total", 32'(tx_got), 20);
      check("wrap_rx_count", 32'(rx_count), 0);
      check("wrap_tx_count", 32'(tx_count), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Byte-wide I/O peripheral on the far side of the CPU's cpuin/cpuout port. It replaces the raw input/output wires with buffered, handshaked channels.
- RX path: the external producer pushes bytes into an RX FIFO. The CPU's load-from-input reads the FIFO head and pops it.
- TX path: the CPU's write-to-output pushes bytes into a TX FIFO. The external consumer drains it over a valid/ready handshake.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- WIDTH, 8, data width in bits; matches the CPU datapath.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_rd  in  1  one-cycle pop strobe from the CPU (load-from-input).
- cpu_in  out  WIDTH  RX FIFO head, driven to the CPU input bus.
- cpu_in_valid  out  1  RX FIFO non-empty.
- cpu_wr  in  1  one-cycle push strobe from the CPU (write-to-output).
- cpu_out  in  WIDTH  byte from the CPU output bus.
- cpu_out_full  out  1  TX FIFO full.
- ext_in_data  in  WIDTH  external producer data.
- ext_in_valid  in  1  external producer valid.
- ext_in_ready  out  1  RX FIFO can accept a byte.
- ext_out_data  out  WIDTH  TX FIFO head.
- ext_out_valid  out  1  TX FIFO non-empty.
- ext_out_ready  in  1  external consumer ready.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.

Behaviour:
- Reset (asynchronous, either FIFO state): pointers and counts = 0; storage is not cleared.
  - Outputs during/after reset: cpu_in=0, cpu_in_valid=0, ext_in_ready=1, ext_out_valid=0, ext_out_data=0, cpu_out_full=0, rx_count=tx_count=0.
  - Reset mid-transfer discards all buffered bytes. The first post-reset edge is a normal cycle.
- FIFO structure: each FIFO is a circular buffer with read/write pointers of $clog2(DEPTH)+1 bits.
  - The MSB is a wrap flag. Pointers wrap modulo 2*DEPTH.
  - empty = pointers equal. full = low bits equal and MSBs differ.
  - count = wptr - rptr, modulo arithmetic at pointer width.
- Show-ahead reads: the head is combinationally visible. A byte pushed on edge N appears on cpu_in / ext_out_data after edge N; zero extra latency.
- Empty FIFO output: cpu_in and ext_out_data are forced to 0 while the respective FIFO is empty, never stale data.
- RX push: occurs when ext_in_valid && ext_in_ready, with ext_in_ready = !rx_full.
  - The producer holds data until the handshake completes.
- RX pop: occurs when cpu_rd && !rx_empty. cpu_rd on an empty FIFO is ignored; no pointer movement.
- TX push: occurs when cpu_wr && !tx_full. cpu_wr while full drops the byte; no state change.
- TX pop: occurs when ext_out_valid && ext_out_ready.
- Simultaneous push and pop on one FIFO:
  - Not empty and not full: both take effect; count unchanged.
  - Full: pop occurs; push blocked (RX ready was low; TX write dropped); count decrements by 1.
  - Empty: push occurs; pop ignored; count becomes 1.
- Independence: RX and TX paths share no state apart from clock and reset.

Optional Feature:
- Macro: CPU_IO_PORT_ERR_EN.
- Defined: adds outputs rx_underflow (1) and tx_overflow (1) and input err_clear (1).
  - rx_underflow sets on cpu_rd while RX is empty.
  - tx_overflow sets on cpu_wr while TX is full.
  - Both flags are sticky until err_clear, which clears them on the next edge. A set event in the same cycle as err_clear wins (flag stays 1).
  - Both flags reset to 0.
- Not defined: ports absent; underflow and overflow are silently ignored as above.

Test Plan:
1. Reset then idle: assert reset mid-cycle -> all outputs read as reset values immediately (asynchronous); ext_in_ready=1, counts=0.
2. RX ordering: push 0x11, 0x22, 0x33 via ext_in, then cpu_rd for 3 cycles -> cpu_in shows 0x11, 0x22, 0x33 in order, then 0x00 with cpu_in_valid=0.
3. RX full and underflow: push 5 bytes with DEPTH=4 -> ext_in_ready=0 after the 4th and the 5th is held. With no further pushes, pop 5 times -> rx_count reaches 0; the 5th cpu_rd is ignored (rx_underflow=1 if CPU_IO_PORT_ERR_EN).
4. TX overflow: with ext_out_ready=0, cpu_wr 0xA0..0xA4 -> tx_count=4 and cpu_out_full=1; 0xA4 dropped. Raise ready -> drains 0xA0..0xA3 in order.
5. Simultaneous events: at tx_count=4, cpu_wr and ext_out_ready in the same cycle -> pop occurs, write dropped, tx_count=3. At rx_count=2, push and pop together -> rx_count stays 2.
6. Wrap-around: stream 20 bytes 0x00..0x13 through each FIFO with random valid/ready -> output order is exact and there is no loss when handshakes are respected.
